multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Parametrised 5-phase multi-cycle CPU sequencer: fetch/decode/execute/memory/writeback with a
//  stallable ready/ack memory port, run/pause/single-step control and an external ALU interface.
//  Owns PC, IR, register file, AR/BR/DR/MDR and the S/Z/C/V flags; sits between top-level I/O and memory.
// PARAMETERS
//  DATA_W  16  datapath/register width (>=16); instruction word is always 16 bits
//  NREG    8   register count (power of 2, <=8; register fields are 3 bits, upper bits ignored)
//  ADDR_W  16  PC and memory address width
// PORTS
//  clock       in   1       system clock, all state on posedge
//  resetN      in   1       async active-low reset
//  exec        in   1       1-cycle pulse: IDLE->run; while running, request pause
//  stepMode    in   1       1: return to IDLE after every writeback
//  inData      in   DATA_W  value read by IDT
//  memAddr     out  ADDR_W  memory address
//  memReq      out  1       memory request, held until memAck
//  memWe       out  1       write strobe, qualifies memReq
//  memWData    out  DATA_W  store data
//  memRData    in   DATA_W  read data, valid with memAck
//  memAck      in   1       completes request in the same cycle
//  aluOp       out  4       ALU select (IR[7:4] for class 11, else 0000 = add)
//  aluA,aluB   out  DATA_W  ALU operands (AR, BR)
//  aluOut      in   DATA_W  ALU result (combinational)
//  aluFlags    in   4       {V,C,Z,S}
//  aluFlagsWe  in   1       flags valid for this op
//  outResult   out  DATA_W  last OUT value
//  outIR       out  16      current instruction
//  outPC       out  ADDR_W  current PC
//  outPhase    out  5       one-hot phase P1..P5, 00000 in IDLE/HALT
//  halted      out  1       HALT executed
// BEHAVIOUR
//  - Reset: state IDLE, PC=0, IR=0, regs/AR/BR/DR/MDR/result=0, flags=0, memReq=memWe=0, halted=0.
//    Reset mid-request drops memReq immediately; no writeback completes.
//  - FSM: IDLE, P1 FETCH, P2 DECODE, P3 EXEC, P4 MEM, P5 WB, HALT. exec in IDLE -> P1 next cycle.
//  - P1: memReq=1, memAddr=PC, memWe=0; stays in P1 until memAck; on ack IR<=memRData, PC<=PC+1, ->P2.
//  - P2 operand latch (imm8 = IR[7:0]):
//    class 11: AR<=R[IR[10:8]]; BR<=zext(imm8) for shifts (1000-1011), inData for IDT, else R[IR[13:11]].
//    class 00/01 (load/store): AR<=R[IR[10:8]], BR<=sext(imm8).
//    class 10 branch: AR<=PC (already incremented), BR<=sext(imm8).
//  - P3: DR<=aluOut, except OUT: result<=AR; HALT: ->HALT state, halted=1 (no P4/P5).
//  - P4: load: memReq, memAddr=DR, wait for ack, MDR<=memRData. store: memReq, memWe=1, memWData=R[IR[13:11]],
//    wait for ack. Other classes pass through P4 in one cycle.
//  - P5: flags<=aluFlags if aluFlagsWe (class 11 only). Write R[IR[10:8]]<=DR for ALU ops except CMP/OUT.
//    load: R[IR[13:11]]<=MDR. LI (10,000): R[IR[10:8]]<=zext(imm8).
//    Branch taken -> PC<=DR[ADDR_W-1:0]: B (10,100) always; 10,111 with IR[10:8]:
//    000 BE Z, 001 BLT S^V, 010 BLE Z|(S^V), 011 BNE !Z; other codes not taken.
//  - After P5: ->IDLE if stepMode or pause pending, else ->P1. Pause is set by exec outside IDLE and cleared on entry to IDLE.
//  - HALT is left only by reset; exec is ignored there.
//  - Address arithmetic wraps modulo 2^ADDR_W; PC=max fetches then wraps to 0.
//  - Simultaneous exec and memAck in P1: ack taken, pause recorded.
// STRUCTURE
//  - Shared package: opcode/class/branch-condition localparams, phase one-hot encodings, flag bit indices.
//  - One natural sub-module: seq_regfile (NREG x DATA_W, 2 async read ports, 1 write port, async clear).
//  - ALU remains external; FSM, PC and pipeline registers stay in this module.
// TESTING
//  1 reset mid-fetch: memReq=1, drop resetN -> memReq=0 same cycle, PC=0, outPhase=0, halted=0.
//  2 LI R1,5; LI R2,3; ADD R1,R2 with memAck after 3 wait cycles -> R1=8, each fetch stalls 3 cycles.
//  3 ST R1,[R0+4] then LD R3,[R0+4] -> memWe write to addr 4 data 8; R3=8.
//  4 CMP R1=2,R2=2 then BE -3 -> branch taken, PC=PC+1-3; repeat with BNE -> PC falls through.
//  5 stepMode=1, exec pulse -> exactly one instruction, then IDLE, outPhase=0.
//  6 IDT with inData=16'hBEEF, OUT, HALT -> outResult=BEEF, halted=1, later exec ignored.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, instruction fields,
// branch conditions, ALU op codes, flag bit positions and one-hot phase codes.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  // Instruction class, IR[15:14]
  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  // Class-10 sub-op, IR[13:11]
  localparam logic [2:0] BR_LI = 3'b000;
  localparam logic [2:0] BR_B  = 3'b100;
  localparam logic [2:0] BR_CC = 3'b111;

  // Conditional branch codes, IR[10:8]
  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  // ALU-class op codes, IR[7:4]; 1000-1011 are shifts
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_IDT  = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  // aluFlags = {V,C,Z,S}
  localparam int FLAG_S = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam logic [4:0] PH_NONE   = 5'b00000;
  localparam logic [4:0] PH_FETCH  = 5'b00001;
  localparam logic [4:0] PH_DECODE = 5'b00010;
  localparam logic [4:0] PH_EXEC   = 5'b00100;
  localparam logic [4:0] PH_MEM    = 5'b01000;
  localparam logic [4:0] PH_WB     = 5'b10000;

  function automatic logic is_shift(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Memory port of the sequencer: request/ack handshake with address, write strobe and data.
interface multicycle_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] memAddr;
  logic              memReq;
  logic              memWe;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;
  logic              memAck;

  modport master (output memAddr, memReq, memWe, memWData, input memRData, memAck);
  modport slave  (input memAddr, memReq, memWe, memWData, output memRData, memAck);
endinterface

// File: rtl/multicycle_sequencer_regfile.sv
// General register file: NREG x DATA_W, two asynchronous read ports, one write port.
// Register fields are 3 bits wide; bits above the index width are ignored.
module seq_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic [2:0]        i_raddr_a,
  input  logic [2:0]        i_raddr_b,
  input  logic              i_we,
  input  logic [2:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [IDX_W-1:0]  w_ia, w_ib, w_iw;

  assign w_ia = i_raddr_a[IDX_W-1:0];
  assign w_ib = i_raddr_b[IDX_W-1:0];
  assign w_iw = i_waddr[IDX_W-1:0];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[w_iw] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[w_ia];
  assign o_rdata_b = r_regs[w_ib];
endmodule

// File: rtl/multicycle_sequencer.sv
// Five-phase multi-cycle CPU sequencer with stallable memory port and external ALU.
//   state    | meaning
//   IDLE     | stopped; exec starts a fetch
//   FETCH    | P1: read IR at PC, held until memAck
//   DECODE   | P2: latch AR/BR operands
//   EXEC     | P3: capture ALU result, OUT, or HALT
//   MEM      | P4: load/store access, one cycle pass-through otherwise
//   WB       | P5: flags, register writeback, branch
//   HALT     | terminal until reset
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 16
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   exec,
  input  logic                   stepMode,
  input  logic [DATA_W-1:0]      inData,
  multicycle_sequencer_if.master mem,
  output logic [3:0]             aluOp,
  output logic [DATA_W-1:0]      aluA,
  output logic [DATA_W-1:0]      aluB,
  input  logic [DATA_W-1:0]      aluOut,
  input  logic [3:0]             aluFlags,
  input  logic                   aluFlagsWe,
  output logic [DATA_W-1:0]      outResult,
  output logic [15:0]            outIR,
  output logic [ADDR_W-1:0]      outPC,
  output logic [4:0]             outPhase,
  output logic                   halted
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_ar, r_br, r_dr, r_mdr, r_result;
  logic [3:0]        r_flags;
  logic              r_pause;

  logic [1:0]        w_cls;
  logic [2:0]        w_ra, w_rb;
  logic [3:0]        w_op;
  logic [7:0]        w_imm;
  logic [DATA_W-1:0] w_sext, w_zext, w_rd_a, w_rd_b, w_wdata;
  logic [2:0]        w_waddr;
  logic              w_we, w_is_ld, w_is_st, w_is_out, w_is_halt, w_take, w_pause;

  assign w_cls     = r_ir[15:14];
  assign w_rb      = r_ir[13:11];
  assign w_ra      = r_ir[10:8];
  assign w_op      = r_ir[7:4];
  assign w_imm     = r_ir[7:0];
  assign w_sext    = {{(DATA_W-8){w_imm[7]}}, w_imm};
  assign w_zext    = {{(DATA_W-8){1'b0}}, w_imm};
  assign w_is_ld   = (w_cls == CLS_LD);
  assign w_is_st   = (w_cls == CLS_ST);
  assign w_is_out  = (w_cls == CLS_ALU) && (w_op == OP_OUT);
  assign w_is_halt = (w_cls == CLS_ALU) && (w_op == OP_HALT);
  assign w_pause   = r_pause | exec;

  seq_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clock     (clock),
    .resetN    (resetN),
    .i_raddr_a (w_ra),
    .i_raddr_b (w_rb),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (exec) w_next = ST_FETCH;
      ST_FETCH:  if (mem.memAck) w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   w_next = w_is_halt ? ST_HALT : ST_MEM;
      ST_MEM:    if (!(w_is_ld || w_is_st) || mem.memAck) w_next = ST_WB;
      ST_WB:     w_next = (stepMode || w_pause) ? ST_IDLE : ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.memReq  = 1'b0;
    mem.memWe   = 1'b0;
    mem.memAddr = r_pc;
    outPhase    = PH_NONE;
    halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem.memReq = 1'b1;
        outPhase   = PH_FETCH;
      end
      ST_DECODE: outPhase = PH_DECODE;
      ST_EXEC:   outPhase = PH_EXEC;
      ST_MEM: begin
        outPhase    = PH_MEM;
        mem.memAddr = ADDR_W'(r_dr);
        mem.memReq  = w_is_ld || w_is_st;
        mem.memWe   = w_is_st;
      end
      ST_WB:   outPhase = PH_WB;
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Conditions use the flags left by the last flag-writing ALU op.
  always_comb begin
    w_take = 1'b0;
    if (w_cls == CLS_BR && w_rb == BR_B) begin
      w_take = 1'b1;
    end else if (w_cls == CLS_BR && w_rb == BR_CC) begin
      case (w_ra)
        CC_BE:   w_take = r_flags[FLAG_Z];
        CC_BLT:  w_take = r_flags[FLAG_S] ^ r_flags[FLAG_V];
        CC_BLE:  w_take = r_flags[FLAG_Z] | (r_flags[FLAG_S] ^ r_flags[FLAG_V]);
        CC_BNE:  w_take = !r_flags[FLAG_Z];
        default: w_take = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_ra;
    w_wdata = r_dr;
    if (r_state == ST_WB) begin
      case (w_cls)
        CLS_ALU: w_we = !(w_op == OP_CMP || w_op == OP_OUT);
        CLS_LD: begin
          w_we    = 1'b1;
          w_waddr = w_rb;
          w_wdata = r_mdr;
        end
        CLS_BR: if (w_rb == BR_LI) begin
          w_we    = 1'b1;
          w_wdata = w_zext;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                               r_pause <= 1'b0;
    else if (w_next == ST_IDLE)                r_pause <= 1'b0;
    else if (exec && r_state != ST_IDLE
             && r_state != ST_HALT)            r_pause <= 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_ar     <= '0;
      r_br     <= '0;
      r_dr     <= '0;
      r_mdr    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: if (mem.memAck) begin
          r_ir <= mem.memRData[15:0];
          r_pc <= r_pc + 1'b1;
        end
        ST_DECODE: begin
          r_ar <= w_rd_a;
          r_br <= w_rd_b;
          case (w_cls)
            CLS_ALU: begin
              if (w_op == OP_IDT)       r_br <= inData;
              else if (is_shift(w_op))  r_br <= w_zext;
            end
            CLS_BR: begin
              r_ar <= DATA_W'(r_pc);
              r_br <= w_sext;
            end
            default: r_br <= w_sext;
          endcase
        end
        ST_EXEC: begin
          if (w_is_out) r_result <= r_ar;
          else          r_dr     <= aluOut;
        end
        ST_MEM: if (w_is_ld && mem.memAck) r_mdr <= mem.memRData;
        ST_WB: begin
          if (w_cls == CLS_ALU && aluFlagsWe) r_flags <= aluFlags;
          if (w_take) r_pc <= ADDR_W'(r_dr);
        end
        default: ;
      endcase
    end
  end

  assign aluOp     = (w_cls == CLS_ALU) ? w_op : OP_ADD;
  assign aluA      = r_ar;
  assign aluB      = r_br;
  assign mem.memWData = w_rd_b;
  assign outResult = r_result;
  assign outIR     = r_ir;
  assign outPC     = r_pc;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboarded bench for multicycle_sequencer: expected memory transactions are queued
// by the stimulus, a monitor pops and compares them on every acknowledged request.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clock    = 1'b0;
  logic          resetN   = 1'b0;
  logic          exec     = 1'b0;
  logic          stepMode = 1'b0;
  logic [DW-1:0] inData   = 16'hBEEF;
  logic [3:0]    aluOp;
  logic [DW-1:0] aluA, aluB, aluOut;
  logic [3:0]    aluFlags;
  logic          aluFlagsWe;
  logic [DW-1:0] outResult;
  logic [15:0]   outIR;
  logic [AW-1:0] outPC;
  logic [4:0]    outPhase;
  logic          halted;

  logic          tb_ack   = 1'b0;
  logic [DW-1:0] tb_rdata = '0;

  multicycle_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();
  assign mem_if.memAck   = tb_ack;
  assign mem_if.memRData = tb_rdata;

  multicycle_sequencer #(.DATA_W(DW), .NREG(8), .ADDR_W(AW)) dut (
    .clock(clock), .resetN(resetN), .exec(exec), .stepMode(stepMode), .inData(inData),
    .mem(mem_if), .aluOp(aluOp), .aluA(aluA), .aluB(aluB), .aluOut(aluOut),
    .aluFlags(aluFlags), .aluFlagsWe(aluFlagsWe), .outResult(outResult), .outIR(outIR),
    .outPC(outPC), .outPhase(outPhase), .halted(halted)
  );

  always #5 clock = ~clock;

  // External ALU: add by default, subtract for SUB/CMP, pass B for IDT
  logic [16:0] alu_wide;
  always_comb begin
    alu_wide   = {1'b0, aluA} + {1'b0, aluB};
    aluFlagsWe = 1'b1;
    case (aluOp)
      OP_SUB, OP_CMP: alu_wide = {1'b0, aluA} - {1'b0, aluB};
      OP_IDT: begin
        alu_wide   = {1'b0, aluB};
        aluFlagsWe = 1'b0;
      end
      default: ;
    endcase
    aluOut   = alu_wide[15:0];
    aluFlags = {1'b0, alu_wide[16], (alu_wide[15:0] == 16'h0), alu_wide[15]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model with programmable wait states
  logic [15:0] mem_arr [256];
  int mem_wait = 0;
  int wcnt = 0;
  always @(negedge clock) begin
    if (tb_ack) begin
      tb_ack = 1'b0;
      wcnt   = 0;
    end else if (mem_if.memReq) begin
      if (wcnt >= mem_wait) begin
        tb_ack = 1'b1;
        if (mem_if.memWe) mem_arr[mem_if.memAddr[7:0]] = mem_if.memWData;
        else              tb_rdata = mem_arr[mem_if.memAddr[7:0]];
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  typedef struct packed {logic we; logic [15:0] addr; logic [15:0] data;} txn_t;
  txn_t exp_q[$];
  txn_t mon_t;
  int req_cycles = 0;

  always @(negedge clock) begin
    #1;
    if (!resetN) begin
      req_cycles = 0;
    end else if (mem_if.memReq) begin
      req_cycles++;
      if (mem_if.memAck) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_txn: addr %h we %b", mem_if.memAddr, mem_if.memWe);
        end else begin
          mon_t = exp_q.pop_front();
          check("txn_we", 32'(mem_if.memWe), 32'(mon_t.we));
          check("txn_addr", 32'(mem_if.memAddr), 32'(mon_t.addr));
          if (mon_t.we) check("txn_wdata", 32'(mem_if.memWData), 32'(mon_t.data));
          check("req_hold_cycles", req_cycles, mem_wait + 1);
        end
        req_cycles = 0;
      end
    end
  end

  function automatic logic [15:0] i_alu(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {2'b11, rs, rd, op, 4'h0};
  endfunction
  function automatic logic [15:0] i_li(input logic [2:0] rd, input logic [7:0] imm);
    return {2'b10, BR_LI, rd, imm};
  endfunction
  function automatic logic [15:0] i_ld(input logic [2:0] rt, input logic [2:0] rb, input logic [7:0] off);
    return {2'b00, rt, rb, off};
  endfunction
  function automatic logic [15:0] i_st(input logic [2:0] rs, input logic [2:0] rb, input logic [7:0] off);
    return {2'b01, rs, rb, off};
  endfunction
  function automatic logic [15:0] i_br(input logic [2:0] sub, input logic [2:0] cc, input logic [7:0] off);
    return {2'b10, sub, cc, off};
  endfunction

  task automatic exp_fetch(input logic [15:0] a); exp_q.push_back({1'b0, a, 16'h0}); endtask
  task automatic exp_read(input logic [15:0] a);  exp_q.push_back({1'b0, a, 16'h0}); endtask
  task automatic exp_write(input logic [15:0] a, input logic [15:0] d); exp_q.push_back({1'b1, a, d}); endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0;
  endtask

  task automatic pulse_exec();
    @(negedge clock); exec = 1'b1;
    @(negedge clock); exec = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock); resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic wait_halt(input int max_cyc);
    int n = 0;
    while (!halted && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    // Reset values, then reset asserted in the middle of a stalled fetch
    clear_mem();
    mem_arr[0] = i_li(3'd1, 8'd5);
    mem_wait   = 3;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    check("rst_pc", 32'(outPC), 32'd0);
    check("rst_ir", 32'(outIR), 32'd0);
    check("rst_phase", 32'(outPhase), 32'd0);
    check("rst_result", 32'(outResult), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_memreq", 32'(mem_if.memReq), 32'd0);
    pulse_exec();
    @(posedge clock); #2;
    check("fetch_req", 32'(mem_if.memReq), 32'd1);
    check("fetch_phase", 32'(outPhase), 32'(PH_FETCH));
    resetN = 1'b0;
    #1;
    check("midreq_memreq", 32'(mem_if.memReq), 32'd0);
    check("midreq_pc", 32'(outPC), 32'd0);
    check("midreq_phase", 32'(outPhase), 32'd0);
    check("midreq_halted", 32'(halted), 32'd0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;

    // Program run with 3 wait states per access
    clear_mem();
    mem_arr[0]  = i_br(BR_B, 3'd0, 8'd15);
    mem_arr[16] = i_li(3'd1, 8'd5);
    mem_arr[17] = i_li(3'd2, 8'd3);
    mem_arr[18] = i_alu(OP_ADD, 3'd1, 3'd2);
    mem_arr[19] = i_st(3'd1, 3'd0, 8'd4);
    mem_arr[20] = i_ld(3'd3, 3'd0, 8'd4);
    mem_arr[21] = i_st(3'd3, 3'd0, 8'd5);
    mem_arr[22] = i_li(3'd1, 8'd2);
    mem_arr[23] = i_li(3'd2, 8'd2);
    mem_arr[24] = i_br(BR_B, 3'd0, 8'd2);
    mem_arr[26] = i_br(BR_B, 3'd0, 8'd4);
    mem_arr[27] = i_alu(OP_CMP, 3'd1, 3'd2);
    mem_arr[28] = i_br(BR_CC, CC_BE, 8'hFD);
    mem_arr[31] = i_br(BR_CC, CC_BNE, 8'hFD);
    mem_arr[32] = i_alu(OP_IDT, 3'd4, 3'd0);
    mem_arr[33] = i_alu(OP_OUT, 3'd4, 3'd0);
    mem_arr[34] = i_alu(OP_HALT, 3'd0, 3'd0);
    mem_wait = 3;
    exp_fetch(16'd0);
    for (int a = 16; a <= 19; a++) exp_fetch(16'(a));
    exp_write(16'd4, 16'd8);
    exp_fetch(16'd20);
    exp_read(16'd4);
    exp_fetch(16'd21);
    exp_write(16'd5, 16'd8);
    exp_fetch(16'd22); exp_fetch(16'd23); exp_fetch(16'd24);
    exp_fetch(16'd27); exp_fetch(16'd28); exp_fetch(16'd26);
    exp_fetch(16'd31); exp_fetch(16'd32); exp_fetch(16'd33); exp_fetch(16'd34);
    pulse_exec();
    wait_halt(3000);
    repeat (2) @(negedge clock);
    check("prog_txn_left", exp_q.size(), 32'd0);
    check("out_result", 32'(outResult), 32'hBEEF);
    check("halt_pc", 32'(outPC), 32'd35);
    check("halt_ir", 32'(outIR), 32'(i_alu(OP_HALT, 3'd0, 3'd0)));
    check("halt_phase", 32'(outPhase), 32'd0);
    pulse_exec();
    repeat (20) @(negedge clock);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_exec_pc", 32'(outPC), 32'd35);
    check("halt_exec_phase", 32'(outPhase), 32'd0);

    // Single-step mode: one instruction per exec pulse
    do_reset();
    clear_mem();
    mem_arr[0] = i_li(3'd5, 8'd7);
    mem_arr[1] = i_st(3'd5, 3'd0, 8'd8);
    mem_wait = 0;
    stepMode = 1'b1;
    exp_fetch(16'd0);
    pulse_exec();
    repeat (20) @(negedge clock);
    check("step1_txn_left", exp_q.size(), 32'd0);
    check("step1_pc", 32'(outPC), 32'd1);
    check("step1_phase", 32'(outPhase), 32'd0);
    exp_fetch(16'd1);
    exp_write(16'd8, 16'd7);
    pulse_exec();
    repeat (20) @(negedge clock);
    check("step2_txn_left", exp_q.size(), 32'd0);
    check("step2_pc", 32'(outPC), 32'd2);
    check("step2_phase", 32'(outPhase), 32'd0);
    stepMode = 1'b0;

    // Pause request while running stops after the current instruction
    do_reset();
    clear_mem();
    mem_arr[0] = i_li(3'd1, 8'd1);
    mem_arr[1] = i_li(3'd2, 8'd2);
    exp_fetch(16'd0);
    pulse_exec();
    pulse_exec();
    repeat (20) @(negedge clock);
    check("pause_txn_left", exp_q.size(), 32'd0);
    check("pause_pc", 32'(outPC), 32'd1);
    check("pause_phase", 32'(outPhase), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
